operand_fetch: RTL

//  Issue stage directly upstream of the ALU. Accepts a decoded op and reads its two operands from an internal register file.

---
 rtl/operand_fetch.sv | 85 ++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: register-file read with writeback forwarding,
// per-register busy scoreboard, and a one-deep valid/ready output register.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic [3:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_busA,
  output logic [DATA_W-1:0] out_busB,
  output logic [3:0]        out_ctrl,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;

  logic              wb_rs, wb_rt, busy_rs, busy_rt, hazard, accept, wb_wr;
  logic [DATA_W-1:0] rd_a, rd_b, imm_x;

  // A writeback landing this cycle both supplies the data and retires the hazard.
  always_comb begin
    wb_rs   = wb_en && (wb_rd == in_rs);
    wb_rt   = wb_en && (wb_rd == in_rt);
    rd_a    = (in_rs == '0) ? '0 : (wb_rs ? wb_data : regs[in_rs]);
    rd_b    = (in_rt == '0) ? '0 : (wb_rt ? wb_data : regs[in_rt]);
    busy_rs = busy[in_rs] & ~wb_rs;
    busy_rt = busy[in_rt] & ~wb_rt;
    hazard  = busy_rs | (~in_use_imm & busy_rt);
    imm_x   = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  end

  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;
  assign wb_wr    = wb_en && (wb_rd != '0);

  // Set after clear, so an issue and a writeback to the same rd leave it busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wb_wr) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      if (accept && (in_rd != '0))
        busy[in_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_busA  <= '0;
      out_busB  <= '0;
      out_ctrl  <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_busA  <= rd_a;
      out_busB  <= in_use_imm ? imm_x : rd_b;
      out_ctrl  <= in_ctrl;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
